decode_ctrl_stage: RTL
======================

// Module: decode_ctrl_stage
// PURPOSE
//  Registered ID stage for the RV32IM pipeline; next generation of the combinational control unit.
//  - Decodes the full 32-bit instruction into control bits, ALU control code, register indices and a sign-extended immediate.
//  - Registers all of it into the ID/EX pipeline register, with a valid/ready handshake on each side.
//  - Adds load-use stall detection, branch flush, and a multi-cycle MUL/DIV issue lock.
// PARAMETERS
//  XLEN        32  datapath / PC / immediate width (32 or 64; instructions are always 32 b)
//  MULDIV_LAT  32  cycles the EX mul/div unit stays busy after accepting an M op (>=1)
//  EN_M        1   1: decode RV32M; 0: M encodings flag illegal
// PORTS
//  clk            in   1     clock
//  rst            in   1     reset (one clock; reset is synchronous and active-high)
//  in_valid       in   1     IF/ID slot holds an instruction
//  in_ready       out  1     stage accepts in_instr/in_pc this cycle
//  in_instr       in   32    instruction word
//  in_pc          in   XLEN  instruction address
//  flush          in   1     branch/jump resolved taken in EX: kill ID/EX contents and the incoming slot
//  ex_mem_read    in   1     instruction currently in EX is a load
//  ex_rd          in   5     destination of the instruction currently in EX
//  out_valid      out  1     ID/EX register holds a live instruction
//  out_ready      in   1     EX accepts ID/EX register
//  out_alu_ctrl   out  5     ALUCTRL_* code
//  out_branch, out_mem_read, out_mem_to_reg, out_mem_write, out_alu_src, out_reg_write  out 1 each
//  out_rs1, out_rs2, out_rd  out  5     register indices
//  out_imm        out  XLEN  sign-extended immediate (I/S/B/U/J format by opcode; 0 for R)
//  out_pc         out  XLEN  PC of decoded instruction
//  out_illegal    out  1     unsupported opcode/funct: all side-effect bits forced 0
//  muldiv_busy    out  1     issue lock active
// BEHAVIOUR
//  - Reset: out_valid=0, all out_* = 0, muldiv_busy=0, FSM=IDLE. Reset mid-operation aborts any lock.
//  - Latency 1 cycle. ID/EX register loads when (!out_valid || out_ready) and in_ready.
//  - Decode: same control truth table as the current unit, with these corrections:
//    - JAL writes rd; reg_write = 0 for S, B, illegal, and rd==x0.
//    - LUI (0110111) is supported: ALUCTRL_ADD, rs1 forced to x0.
//  - Load-use stall: hazard = ex_mem_read && ex_rd!=0 && ex_rd matches a source the incoming op actually reads (rs2 only for R/S/B).
//    On hazard: in_ready=0 and a bubble (out_valid=0) is loaded when EX consumes.
//  - in_ready = !hazard && !muldiv_busy && (!out_valid || out_ready).
//  - FSM IDLE->BUSY when an M op transfers out (out_valid&&out_ready&&is_muldiv) and MULDIV_LAT>1.
//    Counter is loaded with MULDIV_LAT-1 and decrements each cycle; BUSY->IDLE when it reaches 0.
//    muldiv_busy = (state==BUSY).
//  - Flush has priority over everything: next cycle out_valid=0, incoming instruction dropped, FSM->IDLE, counter cleared.
//  - A flush coinciding with a transfer also clears out_valid.
//  - Counter width $clog2(MULDIV_LAT+1); no wrap (saturates at 0).
// STRUCTURE
//  - Shared include alu_control_def.v: ALUCTRL_* codes. Add the opcode constants there too, so they are no longer local parameters.
//  - Sub-module imm_gen (combinational, XLEN param): instruction -> sign-extended immediate.
//  - FSM, hazard logic and pipeline register live in this module.
// TESTING
//  1. add x3,x1,x2 (0x002081B3), out_ready=1 -> next cycle out_valid=1, ALUCTRL_ADD, rd=3, rs1=1, rs2=2, reg_write=1, alu_src=0.
//  2. lw x5,8(x1) (0x0080A283), then add x6,x5,x5 (0x00528333) with ex_mem_read=1, ex_rd=5
//     -> in_ready=0 one cycle, bubble emitted, add issues the following cycle.
//  3. beq x1,x2,+16 (0x00208863) -> branch=1, ALUCTRL_BEQ, imm=16, reg_write=0; flush next cycle -> out_valid=0, queued instr dropped.
//  4. mul x7,x1,x2 (0x022083B3), MULDIV_LAT=4 -> after transfer muldiv_busy=1 for 3 cycles, in_ready=0 throughout, then 1.
//  5. Illegal opcode 0x0000007F -> out_illegal=1, reg_write/mem_write/branch=0; EN_M=0 with 0x022083B3 -> illegal.
//  6. out_ready=0 for 5 cycles with in_valid=1 -> ID/EX contents stable, in_ready=0; assert rst mid-BUSY -> all outputs 0 next edge.

Source files
------------

// File: rtl/decode_ctrl_stage_pkg.sv
// Shared decode definitions for the RV32IM ID stage: ALU control codes, opcodes,
// the decoded control bundle and the control truth table.
package decode_ctrl_stage_pkg;

  localparam int ALUCTRL_W = 5;

  localparam logic [ALUCTRL_W-1:0]
    ALUCTRL_ADD  = 5'd0,  ALUCTRL_SUB  = 5'd1,  ALUCTRL_SLL    = 5'd2,  ALUCTRL_SLT   = 5'd3,
    ALUCTRL_SLTU = 5'd4,  ALUCTRL_XOR  = 5'd5,  ALUCTRL_SRL    = 5'd6,  ALUCTRL_SRA   = 5'd7,
    ALUCTRL_OR   = 5'd8,  ALUCTRL_AND  = 5'd9,  ALUCTRL_BEQ    = 5'd10, ALUCTRL_BNE   = 5'd11,
    ALUCTRL_BLT  = 5'd12, ALUCTRL_BGE  = 5'd13, ALUCTRL_BLTU   = 5'd14, ALUCTRL_BGEU  = 5'd15,
    ALUCTRL_MUL  = 5'd16, ALUCTRL_MULH = 5'd17, ALUCTRL_MULHSU = 5'd18, ALUCTRL_MULHU = 5'd19,
    ALUCTRL_DIV  = 5'd20, ALUCTRL_DIVU = 5'd21, ALUCTRL_REM    = 5'd22, ALUCTRL_REMU  = 5'd23;

  localparam logic [6:0]
    OPC_LOAD   = 7'b0000011, OPC_OP_IMM = 7'b0010011, OPC_AUIPC = 7'b0010111,
    OPC_STORE  = 7'b0100011, OPC_OP     = 7'b0110011, OPC_LUI   = 7'b0110111,
    OPC_BRANCH = 7'b1100011, OPC_JALR   = 7'b1100111, OPC_JAL   = 7'b1101111;

  typedef enum logic {ST_IDLE, ST_BUSY} md_state_e;

  typedef struct packed {
    logic [ALUCTRL_W-1:0] alu_ctrl;
    logic branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
    logic illegal, is_muldiv, use_rs1, use_rs2;
  } ctrl_t;

  function automatic logic [ALUCTRL_W-1:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALUCTRL_SUB : ALUCTRL_ADD;
      3'b001:  return ALUCTRL_SLL;
      3'b010:  return ALUCTRL_SLT;
      3'b011:  return ALUCTRL_SLTU;
      3'b100:  return ALUCTRL_XOR;
      3'b101:  return alt ? ALUCTRL_SRA : ALUCTRL_SRL;
      3'b110:  return ALUCTRL_OR;
      default: return ALUCTRL_AND;
    endcase
  endfunction

  function automatic ctrl_t decode(input logic [31:0] instr, input logic en_m);
    ctrl_t c;
    logic [2:0] f3;
    logic [6:0] f7;
    c  = '0;
    f3 = instr[14:12];
    f7 = instr[31:25];
    case (instr[6:0])
      OPC_OP: begin
        c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; c.reg_write = 1'b1;
        if (f7 == 7'b0000001) begin
          if (en_m) begin
            c.is_muldiv = 1'b1;
            c.alu_ctrl  = ALUCTRL_MUL + ALUCTRL_W'(f3);
          end else c.illegal = 1'b1;
        end else if (f7 == 7'b0000000) c.alu_ctrl = alu_op(f3, 1'b0);
        else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) c.alu_ctrl = alu_op(f3, 1'b1);
        else c.illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        c.use_rs1 = 1'b1; c.alu_src = 1'b1; c.reg_write = 1'b1;
        // shift-immediates carry funct7 in the upper immediate bits
        if (f3 == 3'b001) begin
          if (f7 == 7'b0000000) c.alu_ctrl = ALUCTRL_SLL; else c.illegal = 1'b1;
        end else if (f3 == 3'b101) begin
          if (f7 == 7'b0000000)      c.alu_ctrl = ALUCTRL_SRL;
          else if (f7 == 7'b0100000) c.alu_ctrl = ALUCTRL_SRA;
          else                       c.illegal  = 1'b1;
        end else c.alu_ctrl = alu_op(f3, 1'b0);
      end
      OPC_LOAD: begin
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) c.illegal = 1'b1;
        c.use_rs1 = 1'b1; c.alu_src = 1'b1; c.mem_read = 1'b1; c.mem_to_reg = 1'b1; c.reg_write = 1'b1;
      end
      OPC_STORE: begin
        if (f3[2] || f3 == 3'b011) c.illegal = 1'b1;
        c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; c.alu_src = 1'b1; c.mem_write = 1'b1;
      end
      OPC_BRANCH: begin
        if (f3 == 3'b010 || f3 == 3'b011) c.illegal = 1'b1;
        c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; c.branch = 1'b1;
        c.alu_ctrl = (f3 == 3'b000) ? ALUCTRL_BEQ :
                     (f3 == 3'b001) ? ALUCTRL_BNE : ALUCTRL_BLT + ALUCTRL_W'(f3[1:0]);
      end
      OPC_JAL:  begin c.branch = 1'b1; c.alu_src = 1'b1; c.reg_write = 1'b1; end
      OPC_JALR: begin
        if (f3 != 3'b000) c.illegal = 1'b1;
        c.use_rs1 = 1'b1; c.branch = 1'b1; c.alu_src = 1'b1; c.reg_write = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin c.alu_src = 1'b1; c.reg_write = 1'b1; end
      default: c.illegal = 1'b1;
    endcase
    if (c.illegal) begin
      c = '0;
      c.illegal = 1'b1;
    end
    if (instr[11:7] == 5'd0) c.reg_write = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/decode_ctrl_stage_if.sv
// IF/ID -> ID -> ID/EX handshake bundle, plus the EX-side hazard/flush feedback.
interface decode_ctrl_stage_if #(parameter int XLEN = 32);
  import decode_ctrl_stage_pkg::*;

  logic                 in_valid, in_ready;
  logic [31:0]          in_instr;
  logic [XLEN-1:0]      in_pc;
  logic                 flush, ex_mem_read;
  logic [4:0]           ex_rd;
  logic                 out_valid, out_ready;
  logic [ALUCTRL_W-1:0] out_alu_ctrl;
  logic                 out_branch, out_mem_read, out_mem_to_reg, out_mem_write, out_alu_src, out_reg_write;
  logic [4:0]           out_rs1, out_rs2, out_rd;
  logic [XLEN-1:0]      out_imm, out_pc;
  logic                 out_illegal, muldiv_busy;

  modport master (
    output in_valid, in_instr, in_pc, flush, ex_mem_read, ex_rd, out_ready,
    input  in_ready, out_valid, out_alu_ctrl, out_branch, out_mem_read, out_mem_to_reg,
           out_mem_write, out_alu_src, out_reg_write, out_rs1, out_rs2, out_rd,
           out_imm, out_pc, out_illegal, muldiv_busy
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, ex_mem_read, ex_rd, out_ready,
    output in_ready, out_valid, out_alu_ctrl, out_branch, out_mem_read, out_mem_to_reg,
           out_mem_write, out_alu_src, out_reg_write, out_rs1, out_rs2, out_rd,
           out_imm, out_pc, out_illegal, muldiv_busy
  );
endinterface

// File: rtl/decode_ctrl_stage_imm_gen.sv
// Combinational immediate extractor: picks I/S/B/U/J layout from the opcode and
// sign-extends to XLEN; formats without an immediate yield 0.
module decode_ctrl_stage_imm_gen
  import decode_ctrl_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);
  logic signed [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (instr[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: imm32 = {{20{instr[31]}}, instr[31:20]};
      OPC_STORE:          imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH:         imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC: imm32 = {instr[31:12], 12'b0};
      OPC_JAL:            imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default:            imm32 = '0;
    endcase
  end

  // signed cast keeps the sign extension when XLEN is 64
  assign imm = XLEN'(imm32);
endmodule

// File: rtl/decode_ctrl_stage.sv
// Registered RV32IM decode stage: decode into the ID/EX register with valid/ready
// on both sides, load-use stall, taken-branch flush and a MUL/DIV issue lock.
module decode_ctrl_stage
  import decode_ctrl_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MULDIV_LAT = 32,
  parameter bit EN_M       = 1'b1
) (
  input logic                clk,
  input logic                rst,
  decode_ctrl_stage_if.slave bus
);
  localparam int CNT_W = $clog2(MULDIV_LAT + 1);

  ctrl_t           dec;
  logic [XLEN-1:0] imm;
  logic [4:0]      rs1, rs2;
  logic            hazard, load_en, in_ready, fire, out_is_muldiv;
  md_state_e       state;
  logic [CNT_W-1:0] cnt;

  decode_ctrl_stage_imm_gen #(.XLEN(XLEN)) u_imm_gen (.instr(bus.in_instr), .imm(imm));

  assign dec = decode(bus.in_instr, EN_M);
  assign rs1 = (bus.in_instr[6:0] == OPC_LUI) ? 5'd0 : bus.in_instr[19:15];
  assign rs2 = bus.in_instr[24:20];

  // only registers the incoming op really reads can collide with a pending load
  assign hazard = bus.in_valid && bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                  ((dec.use_rs1 && bus.ex_rd == rs1) || (dec.use_rs2 && bus.ex_rd == rs2));
  assign load_en  = !bus.out_valid || bus.out_ready;
  assign in_ready = !hazard && (state != ST_BUSY) && load_en;
  assign fire     = bus.in_valid && in_ready;

  assign bus.in_ready    = in_ready;
  assign bus.muldiv_busy = (state == ST_BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid      <= 1'b0;
      bus.out_alu_ctrl   <= '0;
      bus.out_branch     <= 1'b0;
      bus.out_mem_read   <= 1'b0;
      bus.out_mem_to_reg <= 1'b0;
      bus.out_mem_write  <= 1'b0;
      bus.out_alu_src    <= 1'b0;
      bus.out_reg_write  <= 1'b0;
      bus.out_illegal    <= 1'b0;
      bus.out_rs1        <= '0;
      bus.out_rs2        <= '0;
      bus.out_rd         <= '0;
      bus.out_imm        <= '0;
      bus.out_pc         <= '0;
      out_is_muldiv      <= 1'b0;
    end else begin
      // a stall leaves fire low, so EX consuming the slot loads a bubble
      if (bus.flush)    bus.out_valid <= 1'b0;
      else if (load_en) bus.out_valid <= fire;
      if (fire && !bus.flush) begin
        bus.out_alu_ctrl   <= dec.alu_ctrl;
        bus.out_branch     <= dec.branch;
        bus.out_mem_read   <= dec.mem_read;
        bus.out_mem_to_reg <= dec.mem_to_reg;
        bus.out_mem_write  <= dec.mem_write;
        bus.out_alu_src    <= dec.alu_src;
        bus.out_reg_write  <= dec.reg_write;
        bus.out_illegal    <= dec.illegal;
        bus.out_rs1        <= rs1;
        bus.out_rs2        <= rs2;
        bus.out_rd         <= bus.in_instr[11:7];
        bus.out_imm        <= imm;
        bus.out_pc         <= bus.in_pc;
        out_is_muldiv      <= dec.is_muldiv;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE:
          if (bus.out_valid && bus.out_ready && out_is_muldiv && MULDIV_LAT > 1) begin
            state <= ST_BUSY;
            cnt   <= CNT_W'(MULDIV_LAT - 1);
          end
        ST_BUSY:
          if (cnt <= CNT_W'(1)) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else cnt <= cnt - 1'b1;
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end
endmodule
